// File: rtl/id_scoreboard.sv
// ID-stage interlock and forwarding-select unit: tracks every in-flight register
// write by pipeline age and reports load-use hazards and the bypass source per operand.
module id_scoreboard #(
    parameter int REG_NUM    = 32,
    parameter int REG_AW     = 5,
    parameter int STAGES     = 3,
    parameter int AGE_W      = 2,
    parameter int ALU_READY  = 1,
    parameter int LOAD_READY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic               src1_en,
    input  logic [REG_AW-1:0]  src1_addr,
    input  logic               src2_en,
    input  logic [REG_AW-1:0]  src2_addr,
    input  logic               dst_we,
    input  logic [REG_AW-1:0]  dst_addr,
    input  logic               dst_is_load,
    input  logic               ex_stall,
    input  logic               flush,
    output logic               stallreq,
    output logic               issue,
    output logic [AGE_W-1:0]   fwd_sel1,
    output logic [AGE_W-1:0]   fwd_sel2,
    output logic [REG_NUM-1:0] busy_vec
);

    localparam logic [AGE_W-1:0]  ALU_RDY_C  = AGE_W'(ALU_READY);
    localparam logic [AGE_W-1:0]  LOAD_RDY_C = AGE_W'(LOAD_READY);
    localparam logic [AGE_W-1:0]  LAST_AGE_C = AGE_W'(STAGES);
    localparam logic [AGE_W-1:0]  AGE_ONE_C  = AGE_W'(1);
    localparam logic [REG_AW-1:0] R0_C       = {REG_AW{1'b0}};

    logic [REG_NUM-1:0]            pend_r;
    logic [REG_NUM-1:0]            ld_r;
    logic [REG_NUM-1:0][AGE_W-1:0] age_r;

    logic hazard1_s;
    logic hazard2_s;
    logic install_s;

    // Operand 1 lookup against current entries (this cycle's issue is not visible yet)
    always_comb begin
        hazard1_s = 1'b0;
        fwd_sel1  = {AGE_W{1'b0}};
        if (src1_en && (src1_addr != R0_C) && pend_r[src1_addr]) begin
            fwd_sel1  = age_r[src1_addr];
            hazard1_s = (age_r[src1_addr] < (ld_r[src1_addr] ? LOAD_RDY_C : ALU_RDY_C));
        end else begin
            hazard1_s = 1'b0;
            fwd_sel1  = {AGE_W{1'b0}};
        end
    end

    // Operand 2 lookup, same rule as operand 1
    always_comb begin
        hazard2_s = 1'b0;
        fwd_sel2  = {AGE_W{1'b0}};
        if (src2_en && (src2_addr != R0_C) && pend_r[src2_addr]) begin
            fwd_sel2  = age_r[src2_addr];
            hazard2_s = (age_r[src2_addr] < (ld_r[src2_addr] ? LOAD_RDY_C : ALU_RDY_C));
        end else begin
            hazard2_s = 1'b0;
            fwd_sel2  = {AGE_W{1'b0}};
        end
    end

    // Interlock and issue decision; issue is masked while reset is asserted
    always_comb begin
        stallreq  = id_valid & (hazard1_s | hazard2_s);
        issue     = rst & id_valid & ~stallreq & ~ex_stall & ~flush;
        install_s = issue & dst_we & (dst_addr != R0_C);
    end

    // Entry aging, retirement and installation; r0 is never written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r <= {REG_NUM{1'b0}};
            ld_r   <= {REG_NUM{1'b0}};
            age_r  <= '0;
        end else if (flush) begin
            pend_r <= {REG_NUM{1'b0}};
            ld_r   <= {REG_NUM{1'b0}};
            age_r  <= '0;
        end else if (!ex_stall) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (pend_r[i]) begin
                    if (age_r[i] == LAST_AGE_C) begin
                        pend_r[i] <= 1'b0;
                        ld_r[i]   <= 1'b0;
                        age_r[i]  <= {AGE_W{1'b0}};
                    end else begin
                        age_r[i] <= age_r[i] + AGE_ONE_C;
                    end
                end
            end
            // Newest producer overrides any older entry for the same register
            if (install_s) begin
                pend_r[dst_addr] <= 1'b1;
                age_r[dst_addr]  <= AGE_ONE_C;
                ld_r[dst_addr]   <= dst_is_load;
            end
        end
    end

    assign busy_vec = pend_r;

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed scenarios with literal expectations plus
// randomized traffic checked against a pipeline-occupancy model (who sits in EX/MEM/WB).
module tb_id_scoreboard;
    localparam int RN = 32;
    localparam int RA = 5;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          id_valid = 1'b0;
    logic          src1_en = 1'b0;
    logic [RA-1:0] src1_addr = '0;
    logic          src2_en = 1'b0;
    logic [RA-1:0] src2_addr = '0;
    logic          dst_we = 1'b0;
    logic [RA-1:0] dst_addr = '0;
    logic          dst_is_load = 1'b0;
    logic          ex_stall = 1'b0;
    logic          flush = 1'b0;
    logic          stallreq;
    logic          issue;
    logic [AW-1:0] fwd_sel1;
    logic [AW-1:0] fwd_sel2;
    logic [RN-1:0] busy_vec;

    id_scoreboard #(
        .REG_NUM(RN), .REG_AW(RA), .STAGES(3), .AGE_W(AW), .ALU_READY(1), .LOAD_READY(2)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .src1_en(src1_en), .src1_addr(src1_addr), .src2_en(src2_en), .src2_addr(src2_addr),
        .dst_we(dst_we), .dst_addr(dst_addr), .dst_is_load(dst_is_load),
        .ex_stall(ex_stall), .flush(flush), .stallreq(stallreq), .issue(issue),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: slot k (1=EX, 2=MEM, 3=WB) holds the register-writing instruction at that age
    bit pv[1:3];
    int pd[1:3];
    bit pl[1:3];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic void model_clear();
        for (int k = 1; k <= 3; k++) begin
            pv[k] = 1'b0; pd[k] = 0; pl[k] = 1'b0;
        end
    endfunction

    // Youngest producer of register a decides the bypass age and whether it is ready
    function automatic void lookup(input logic en, input logic [RA-1:0] a,
                                   output logic haz, output logic [AW-1:0] f);
        haz = 1'b0;
        f   = '0;
        if (en && a != 0) begin
            for (int k = 3; k >= 1; k--) begin
                if (pv[k] && pd[k] == int'(a)) begin
                    f   = AW'(k);
                    haz = pl[k] && (k < 2);
                end
            end
        end
    endfunction

    function automatic logic model_issue();
        logic h1, h2;
        logic [AW-1:0] f1, f2;
        lookup(src1_en, src1_addr, h1, f1);
        lookup(src2_en, src2_addr, h2, f2);
        return rst && id_valid && !(h1 || h2) && !ex_stall && !flush;
    endfunction

    task automatic check_model();
        logic h1, h2, e_stall, e_issue;
        logic [AW-1:0] f1, f2;
        logic [RN-1:0] e_busy;
        lookup(src1_en, src1_addr, h1, f1);
        lookup(src2_en, src2_addr, h2, f2);
        e_stall = id_valid && (h1 || h2);
        e_issue = model_issue();
        e_busy  = '0;
        for (int k = 1; k <= 3; k++) if (pv[k]) e_busy[pd[k]] = 1'b1;
        cmp("m_stallreq", {31'd0, stallreq}, {31'd0, e_stall});
        cmp("m_issue",    {31'd0, issue},    {31'd0, e_issue});
        cmp("m_fwd_sel1", {30'd0, fwd_sel1}, {30'd0, f1});
        cmp("m_fwd_sel2", {30'd0, fwd_sel2}, {30'd0, f2});
        cmp("m_busy_vec", busy_vec, e_busy);
    endtask

    // One clock: compare against the model, then advance it with the sampled inputs
    task automatic step();
        logic iss, fl, st, rs, we, ld;
        int d;
        check_model();
        iss = model_issue(); fl = flush; st = ex_stall; rs = rst;
        we = dst_we; d = int'(dst_addr); ld = dst_is_load;
        @(posedge clk);
        if (!rs || fl) model_clear();
        else if (!st) begin
            pv[3] = pv[2]; pd[3] = pd[2]; pl[3] = pl[2];
            pv[2] = pv[1]; pd[2] = pd[1]; pl[2] = pl[1];
            pv[1] = iss && we && (d != 0); pd[1] = d; pl[1] = ld;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic e1, input int a1, input logic e2, input int a2,
                         input logic we, input int d, input logic ld);
        id_valid = v; src1_en = e1; src1_addr = RA'(a1); src2_en = e2; src2_addr = RA'(a2);
        dst_we = we; dst_addr = RA'(d); dst_is_load = ld; ex_stall = 1'b0; flush = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        model_clear();
        // Reset then idle
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        cmp("rst_busy", busy_vec, 32'd0);
        cmp("rst_stall", {31'd0, stallreq}, 32'd0);
        cmp("rst_fwd", {30'd0, fwd_sel1} | {30'd0, fwd_sel2}, 32'd0);
        idle(1);

        // ALU back-to-back on $8
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 8, 1'b0);
        cmp("alu_issue", {31'd0, issue}, 32'd1);
        step();
        drive(1'b1, 1'b1, 8, 1'b0, 0, 1'b0, 0, 1'b0);
        cmp("alu_stall", {31'd0, stallreq}, 32'd0);
        cmp("alu_fwd_a1", {30'd0, fwd_sel1}, 32'd1);
        step();
        cmp("alu_fwd_a2", {30'd0, fwd_sel1}, 32'd2);
        step();
        cmp("alu_fwd_a3", {30'd0, fwd_sel1}, 32'd3);
        step();
        cmp("alu_fwd_ret", {30'd0, fwd_sel1}, 32'd0);
        cmp("alu_busy8", {31'd0, busy_vec[8]}, 32'd0);
        idle(1);

        // Load-use on $9: exactly one bubble
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 9, 1'b1);
        step();
        drive(1'b1, 1'b0, 0, 1'b1, 9, 1'b0, 0, 1'b0);
        cmp("lu_stall", {31'd0, stallreq}, 32'd1);
        cmp("lu_issue0", {31'd0, issue}, 32'd0);
        cmp("lu_fwd1", {30'd0, fwd_sel2}, 32'd1);
        step();
        cmp("lu_nostall", {31'd0, stallreq}, 32'd0);
        cmp("lu_issue1", {31'd0, issue}, 32'd1);
        cmp("lu_fwd2", {30'd0, fwd_sel2}, 32'd2);
        idle(4);

        // Write-after-write on $5: newest producer wins
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 5, 1'b0);
        step();
        step();
        drive(1'b1, 1'b1, 5, 1'b0, 0, 1'b0, 0, 1'b0);
        cmp("waw_fwd", {30'd0, fwd_sel1}, 32'd1);
        idle(4);

        // ex_stall freezes a pending load, then flush discards everything
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 3, 1'b1);
        step();
        drive(1'b1, 1'b1, 3, 1'b0, 0, 1'b0, 0, 1'b0);
        ex_stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            cmp("stl_stall", {31'd0, stallreq}, 32'd1);
            cmp("stl_fwd", {30'd0, fwd_sel1}, 32'd1);
            cmp("stl_issue", {31'd0, issue}, 32'd0);
            step();
        end
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 4, 1'b0);
        flush = 1'b1;
        #1;
        cmp("fl_issue", {31'd0, issue}, 32'd0);
        step();
        cmp("fl_busy", busy_vec, 32'd0);
        idle(1);

        // r0 is never tracked
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b1);
        step();
        drive(1'b1, 1'b1, 0, 1'b1, 0, 1'b0, 0, 1'b0);
        cmp("r0_busy", busy_vec, 32'd0);
        cmp("r0_stall", {31'd0, stallreq}, 32'd0);
        step();

        // Asynchronous reset with three pending entries
        for (int r = 10; r < 13; r++) begin
            drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, r, 1'b0);
            step();
        end
        idle(0);
        cmp("ar_pre", busy_vec, 32'h0000_1C00);
        #2 rst = 1'b0;
        model_clear();
        #1;
        cmp("ar_busy", busy_vec, 32'd0);
        step();
        rst = 1'b1;
        idle(1);

        // Randomized traffic over a small register window to force collisions
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1);
            ex_stall = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                model_clear();
            end else begin
                rst = 1'b1;
            end
            #1;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Parametrised interlock and forwarding-select unit for the ID stage of the 5-stage MIPS pipeline.
- Tracks every in-flight register write by its pipeline age (EX/MEM/WB).
- Raises stallreq on load-use and long-latency hazards, and tells the operand muxes which bypass source (EX, MEM, WB or regfile) holds the newest value of each source register.
- Sits beside ID, driven by the decoded fields; replaces fixed compare-against-bus forwarding with a per-register scoreboard.

Parameters:
- REG_NUM, 32, number of architectural registers
- REG_AW, 5, register address width (log2 REG_NUM)
- STAGES, 3, pipeline stages after ID that can hold a pending write (EX=1 .. WB=STAGES)
- AGE_W, 2, age counter width; must satisfy 2^AGE_W > STAGES
- ALU_READY, 1, age at which a non-load result becomes forwardable
- LOAD_READY, 2, age at which a load result becomes forwardable

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous and active-low (asserted at 0)
- id_valid  in  1  ID holds a valid decoded instruction
- src1_en  in  1  instruction reads src1_addr
- src1_addr  in  REG_AW  first source register (rs)
- src2_en  in  1  instruction reads src2_addr
- src2_addr  in  REG_AW  second source register (rt)
- dst_we  in  1  instruction writes the register file
- dst_addr  in  REG_AW  destination register
- dst_is_load  in  1  destination value comes from data RAM
- ex_stall  in  1  downstream pipeline is frozen this cycle
- flush  in  1  discard all in-flight writes (exception / full pipe flush)
- stallreq  out  1  hazard: ID must hold
- issue  out  1  instruction leaves ID this cycle
- fwd_sel1  out  AGE_W  bypass source for src1: 0 regfile, k = producer at age k
- fwd_sel2  out  AGE_W  same for src2
- busy_vec  out  REG_NUM  bit r = register r has a pending write

Behaviour:
- State per register r: pend[r] (1b), age[r] (AGE_W), ld[r] (1b).
- Reset (rst=0, async): all pend/age/ld = 0, so busy_vec=0, stallreq=0, issue=0, fwd_sel1/2=0. Reset mid-operation drops all entries with no residue.
- Register 0 is never tracked. A write to r0 creates no entry, and reads of r0 never hazard; fwd_sel=0.
- Lookup is combinational on current state, not including this cycle's issue.
  - For src s with en=1, addr≠0 and pend: ready = age ≥ (ld ? LOAD_READY : ALU_READY).
  - hazard_s = pend & ~ready; otherwise hazard_s = 0.
  - fwd_sel_s = age[addr] when pend and en, else 0.
- stallreq = id_valid & (hazard_1 | hazard_2).
- issue = id_valid & ~stallreq & ~ex_stall & ~flush.
- Clock edge, priority flush > ex_stall > normal:
  - flush: every pend cleared; any issue this cycle is suppressed (issue already 0).
  - ex_stall=1: all entries hold (age frozen); no issue.
  - Normal, for every pend entry: if age==STAGES, clear pend (written to regfile this edge); else age+1.
  - Then, if issue & dst_we & dst_addr≠0: pend=1, age=1, ld=dst_is_load. This overwrites any older entry for the same register, so the newest producer wins.
- An instruction reading and writing the same register checks against the older producer, then installs its own entry.
- Latency:
  - ALU result: forwardable the cycle after issue (age 1).
  - Load: forwardable at age 2, giving exactly one bubble on back-to-back load-use.
- Boundary cases:
  - Age never exceeds STAGES.
  - At most one entry per register.
  - When ex_stall and stallreq are both 1, state holds and stallreq stays asserted.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release → busy_vec=0, stallreq=0, fwd_sel1=fwd_sel2=0.
- ALU back-to-back: issue addiu $8 (dst 8, non-load); next cycle src1_addr=8 → stallreq=0, fwd_sel1=1. Following cycle → fwd_sel1=2, then 3, then 0; busy_vec[8] clears after 3 unstalled cycles.
- Load-use: issue lw $9; next cycle src2_addr=9 → stallreq=1, issue=0, fwd_sel2=1. Next cycle → stallreq=0, issue=1, fwd_sel2=2.
- Write-after-write: issue ori $5, then lui $5 → entry age resets to 1 with ld=0; a reader of $5 gets fwd_sel=1 (newest producer), not 2.
- ex_stall and flush: pending load $3 at age 1, ex_stall=1 for 3 cycles → age stays 1 and stallreq stays 1 for a $3 reader. Then flush=1 with id_valid issuing dst 4 → busy_vec=0 next cycle, no entry for $4.
- r0 and async reset: writes to $0 leave busy_vec[0]=0; reads of $0 give stallreq=0. Dropping rst mid-cycle with 3 pending entries → busy_vec=0 immediately, without waiting for a clock edge.
